prog_loader: RTL and testbench

Byte-stream program loader that fills the MIPS instruction memory before the core runs. Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them to consecutive instruction-memory word addresses, verifies an XOR checksum, and only then releases the datapath from reset. It sits between the host/UART byte source and the instruction memory write port. It is the writer side of the memory the datapath fetches from.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/prog_loader_if.sv | 21 ++
 rtl/word_assembler.sv | 34 +++
 rtl/prog_loader.sv | 123 ++++++++++++
 tb/tb_prog_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and sizes for the program loader: FSM states and frame geometry.
package loader_pkg;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input handshake and instruction-memory write port of the loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shift register with running XOR checksum of every shifted byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] csum,
  output logic              word_full_c
);

  localparam int unsigned IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word <= '0;
      csum <= '0;
      idx  <= '0;
    end else if (shift) begin
      word <= {word[WORD_W-BYTE_W-1:0], din};
      csum <= csum ^ din;
      idx  <= idx + IDX_W'(1);
    end
  end

  // High while the next shifted byte completes the current word.
  assign word_full_c = (idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: fills instruction memory, verifies XOR checksum, then releases core reset.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus,
  output logic          core_rst,
  output logic          done,
  output logic          err
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned CMP_W = CNT_W + 1;
  localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic              accept_c;
  logic              asm_clear_c;
  logic              asm_shift_c;
  logic              ready_nxt_c;
  logic              word_full_c;
  logic              ready;
  logic [BYTE_W-1:0] cnt_hi;
  logic [CNT_W-1:0]  n_words;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] csum;
  logic [CMP_W-1:0]  n_hdr_c;
  logic              last_word_c;

  assign accept_c    = bus.in_valid && ready;
  assign n_hdr_c     = {1'b0, cnt_hi, bus.in_data};
  assign last_word_c = (CMP_W'(idx) + CMP_W'(1)) == {1'b0, n_words};

  word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (asm_clear_c),
    .shift       (asm_shift_c),
    .din         (bus.in_data),
    .word        (word),
    .csum        (csum),
    .word_full_c (word_full_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    asm_clear_c = 1'b0;
    asm_shift_c = 1'b0;
    case (state)
      ST_IDLE: begin
        asm_clear_c = 1'b1;
        if (accept_c) state_nxt = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        if (accept_c) begin
          if (n_hdr_c == '0)            state_nxt = ST_CSUM;
          else if (n_hdr_c > MAX_WORDS) state_nxt = ST_ERROR;
          else                          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          asm_shift_c = 1'b1;
          if (word_full_c) state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: state_nxt = last_word_c ? ST_CSUM : ST_DATA;
      ST_CSUM: begin
        if (accept_c) state_nxt = (csum == bus.in_data) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  state_nxt = ST_DONE;
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Ready is a pure function of the state the FSM is entering.
  always_comb begin
    ready_nxt_c = 1'b0;
    case (state_nxt)
      ST_IDLE, ST_HDR_LO, ST_DATA, ST_CSUM: ready_nxt_c = 1'b1;
      default:                              ready_nxt_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hi     <= '0;
      n_words    <= '0;
      idx        <= '0;
      ready      <= 1'b0;
      bus.mem_we <= 1'b0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (state == ST_IDLE && accept_c)   cnt_hi  <= bus.in_data;
      if (state == ST_HDR_LO && accept_c) n_words <= n_hdr_c[CNT_W-1:0];
      if (state == ST_WRITE)              idx     <= idx + IDX_W'(1);
      ready      <= ready_nxt_c;
      bus.mem_we <= (state_nxt == ST_WRITE);
      core_rst   <= (state_nxt != ST_DONE);
      done       <= (state_nxt == ST_DONE);
      err        <= (state_nxt == ST_ERROR);
    end
  end

  // Word register and index hold steady for the whole WRITE cycle.
  assign bus.in_ready  = ready;
  assign bus.mem_addr  = idx[ADDR_W-1:0];
  assign bus.mem_wdata = word;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a frame-level reference model.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CAP    = 1 << ADDR_W;

  logic clk;
  logic rst;
  logic core_rst;
  logic done;
  logic err;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [31:0]       exp_data_q [$];
  bit                term_on   = 1'b0;
  bit                term_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model_csum(input logic [31:0] w[$]);
    logic [7:0] x = 8'h00;
    foreach (w[i]) x = x ^ w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    return x;
  endfunction

  // Compare process: every write must match the next expected write; terminal states are frozen.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        failures++;
        $display("FAIL mem_write_unexpected actual addr=0x%0h data=0x%0h required=no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr_q.pop_front()));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(exp_data_q.pop_front()));
      end
    end
    if (term_on) begin
      chk("term_in_ready", 64'(bus.in_ready), 64'(0));
      chk("term_done", 64'(done), 64'(term_done));
      chk("term_err", 64'(err), 64'(!term_done));
      chk("term_core_rst", 64'(core_rst), 64'(!term_done));
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    term_on = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    chk("rst_core_rst", 64'(core_rst), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'(1));
  endtask

  // Presents one byte (with optional random bubbles); returns just before the accepting edge.
  task automatic push_byte(input logic [7:0] b, input bit gaps);
    for (int tries = 0; tries < 100; tries++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (bus.in_ready) return;
      end
    end
    checks++;
    failures++;
    $display("FAIL push_timeout actual=in_ready low for 100 cycles required=byte 0x%0h accepted", b);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] n, input logic [31:0] w[$],
                           input logic [7:0] flip, input bit gaps, input bit abort_after3);
    logic [7:0] bytes_q [$];
    bit         too_big = (32'(n) > CAP);
    bit         exp_ok  = !too_big && (flip == 8'h00);
    int         t0      = 0;
    int         lat;
    bit         seen    = 1'b0;

    bytes_q.push_back(n[15:8]);
    bytes_q.push_back(n[7:0]);
    if (!too_big) begin
      foreach (w[i]) begin
        bytes_q.push_back(w[i][31:24]);
        bytes_q.push_back(w[i][23:16]);
        bytes_q.push_back(w[i][15:8]);
        bytes_q.push_back(w[i][7:0]);
        if (!abort_after3) begin
          exp_addr_q.push_back(ADDR_W'(i));
          exp_data_q.push_back(w[i]);
        end
      end
      bytes_q.push_back(model_csum(w) ^ flip);
    end
    if (abort_after3) bytes_q = bytes_q[0:4];

    foreach (bytes_q[i]) begin
      push_byte(bytes_q[i], gaps);
      if (i == 0) t0 = cyc;
    end
    if (abort_after3) begin
      reset_dut();
      return;
    end

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (done || err) begin
        seen = 1'b1;
        break;
      end
    end
    lat = cyc - t0;
    chk({tag, "_finished"}, 64'(seen), 64'(1));
    chk({tag, "_done"}, 64'(done), 64'(exp_ok));
    chk({tag, "_err"}, 64'(err), 64'(!exp_ok));
    chk({tag, "_core_rst"}, 64'(core_rst), 64'(!exp_ok));
    chk({tag, "_writes_left"}, 64'(exp_addr_q.size()), 64'(0));
    if (!gaps) chk({tag, "_latency"}, 64'(lat), too_big ? 64'(2) : 64'(2 + 5 * int'(n) + 1));

    // Keep offering bytes; a finished loader must ignore them.
    term_done = exp_ok;
    term_on   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    term_on = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    logic [31:0] w2 [$];
    logic [31:0] w1 [$];
    logic [31:0] wr [$];

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    w2 = '{32'h20010005, 32'h20020003};
    w1 = '{32'h8C080000};

    reset_dut();

    chk("model_csum_w2", 64'(model_csum(w2)), 64'h05);
    chk("model_csum_w1", 64'(model_csum(w1)), 64'h84);

    run_frame("n2_good", 16'd2, w2, 8'h00, 1'b0, 1'b0);
    reset_dut();
    run_frame("n2_badcsum", 16'd2, w2, 8'h01, 1'b0, 1'b0);
    reset_dut();
    wr.delete();
    run_frame("n0", 16'd0, wr, 8'h00, 1'b0, 1'b0);
    reset_dut();
    run_frame("n_too_big", 16'h0101, wr, 8'h00, 1'b0, 1'b0);
    reset_dut();
    run_frame("n2_gaps", 16'd2, w2, 8'h00, 1'b1, 1'b0);
    reset_dut();
    run_frame("abort", 16'd2, w2, 8'h00, 1'b0, 1'b1);
    run_frame("n1_after_abort", 16'd1, w1, 8'h00, 1'b0, 1'b0);
    reset_dut();

    for (int i = 0; i < CAP; i++) wr.push_back($urandom);
    run_frame("n_max", 16'(CAP), wr, 8'h00, 1'b1, 1'b0);
    reset_dut();

    for (int f = 0; f < 6; f++) begin
      int nw = $urandom_range(1, 8);
      wr.delete();
      for (int i = 0; i < nw; i++) wr.push_back($urandom);
      run_frame("rand", 16'(nw), wr, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                1'($urandom_range(0, 1)), 1'b0);
      reset_dut();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule
